tag_sync: RTL
=============

Name: tag_sync

Overview:
- Upstream tag controller for an array of NUM_TAG double-buffer tag slots; each slot is one per-tag state machine (FREE -> LDMEM -> COMPUTE <-> COMPUTE_CHECK -> STMEM -> FREE).
- Allocates slots round-robin to incoming block requests, steers reuse/flush to the most recently allocated slot, and keeps separate ldmem/compute/stmem pointers.
- Decodes each stage's single done strobe to the owning slot, so load, compute and store engines each see one tag interface.

Parameters:
- NUM_TAG, 2, number of tag slots (>=2, any integer; need not be a power of two).
- TAG_W, $clog2(NUM_TAG), tag index width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- tag_req  in  1  request a new slot; accepted when tag_req && tag_ready.
- tag_reuse  in  1  reuse the last allocated slot for another compute pass.
- tag_flush  in  1  mark the last allocated slot as final (flush).
- tag_ready  out  1  slot_free[alloc_tag].
- tag_done  out  1  all slots free and no request accepted this cycle.
- alloc_tag  out  TAG_W  next slot to be allocated.
- slot_tag_req  out  NUM_TAG  one-hot request to slot alloc_tag.
- slot_tag_reuse  out  NUM_TAG  one-hot reuse to last_tag.
- slot_tag_flush  out  NUM_TAG  one-hot flush to last_tag.
- slot_free  in  NUM_TAG  per-slot FREE.
- slot_ldmem_ready, slot_compute_ready, slot_stmem_ready  in  NUM_TAG  per-slot stage ready.
- slot_next_compute  in  NUM_TAG  per-slot "compute finished, flushed".
- ldmem_tag, compute_tag, stmem_tag  out  TAG_W  stage pointers.
- ldmem_tag_ready, compute_tag_ready, stmem_tag_ready  out  1  slot_X_ready[X_tag].
- ldmem_tag_done, compute_tag_done, stmem_tag_done  in  1  stage done strobes.
- slot_ldmem_done, slot_compute_done, slot_stmem_done  out  NUM_TAG  one-hot decode of done at the stage pointer.

Behaviour:
- Registered state: alloc_tag, last_tag, last_valid, ldmem_tag, compute_tag, stmem_tag. All other outputs are combinational decodes of this state and the inputs (zero latency).
- Reset (async, active-high): all pointers 0, last_tag 0, last_valid 0. With no inputs asserted, every slot_* output is 0.
- Allocation: when tag_req && tag_ready:
  - slot_tag_req[alloc_tag] = 1 in the same cycle.
  - Next edge: last_tag <= alloc_tag, last_valid <= 1, alloc_tag <= (alloc_tag == NUM_TAG-1) ? 0 : alloc_tag+1.
  - tag_req with tag_ready = 0 is not forwarded and does not change state.
- Reuse: slot_tag_reuse[last_tag] = tag_reuse && last_valid && !(tag_req && tag_ready). When a request is accepted in the same cycle, the request wins and the reuse is dropped.
- Flush: slot_tag_flush[last_tag] = tag_flush && last_valid. A flush in the same cycle as an accepted request targets the previous last_tag, not the new slot. Flush is not stateful here; the slot latches it.
- Load path: slot_ldmem_done[ldmem_tag] = ldmem_tag_done && ldmem_tag_ready. On that event ldmem_tag advances with wrap. A done strobe without the matching ready is dropped and the pointer holds.
- Compute path:
  - slot_compute_done[compute_tag] = compute_tag_done && compute_tag_ready.
  - compute_tag advances only when slot_next_compute[compute_tag] = 1, because reused slots return to COMPUTE several times.
  - slot_next_compute bits from non-pointer slots are ignored.
- Store path: slot_stmem_done[stmem_tag] = stmem_tag_done && stmem_tag_ready. On that event stmem_tag advances with wrap.
- Wrap: every pointer wraps to 0 after NUM_TAG-1.
- Full: when all slots are busy, tag_ready = 0 until slot alloc_tag returns to FREE.
- tag_done = (&slot_free) && !(tag_req && tag_ready).
- Reset mid-operation: pointers clear immediately, without waiting for a clock edge. Slots are expected to be reset by the same reset.

Test Plan:
- Reset/idle: assert reset asynchronously between clock edges -> all pointers 0 immediately; with slot_free = all 1, tag_ready = 1 and tag_done = 1.
- Round-robin, NUM_TAG=2:
  - tag_req for 3 cycles, slot_free = 2'b11 then 2'b10 then 2'b00 -> slot_tag_req = 01, then 10, then 00.
  - alloc_tag goes 0, 1, 0; tag_ready = 0 on the third cycle.
- Reuse/flush steering: allocate slot 0, then assert tag_reuse and tag_flush -> slot_tag_reuse = 01 and slot_tag_flush = 01. Same cycle as a new accepted req -> slot_tag_req = 10, slot_tag_reuse = 00, slot_tag_flush = 01.
- Compute pointer holds across reuse:
  - compute_tag_done three times with slot_compute_ready[0] = 1 -> slot_compute_done = 01 each time, compute_tag stays 0.
  - Pulse slot_next_compute = 01 -> compute_tag = 1 next cycle.
- Stage done gating: stmem_tag_done with slot_stmem_ready = 00 -> slot_stmem_done = 00 and stmem_tag unchanged; with slot_stmem_ready = 01 -> slot_stmem_done = 01 and stmem_tag goes to 1.
- NUM_TAG=3 wrap: 6 accepted requests with all slots free -> alloc_tag sequence 0, 1, 2, 0, 1, 2, then 0.

Source files
------------

// File: rtl/tag_sync_if.sv
// tag_sync_if : tag-controller bus (upstream request, per-slot status/strobes, stage engines)
// rev 1.0
`default_nettype none

interface tag_sync_if #(
   parameter int NUM_TAG = 2,
   parameter int TAG_W   = $clog2(NUM_TAG)
);
   logic               tag_req;
   logic               tag_reuse;
   logic               tag_flush;
   logic               tag_ready;
   logic               tag_done;
   logic [TAG_W-1:0]   alloc_tag;
   logic [NUM_TAG-1:0] slot_tag_req;
   logic [NUM_TAG-1:0] slot_tag_reuse;
   logic [NUM_TAG-1:0] slot_tag_flush;
   logic [NUM_TAG-1:0] slot_free;
   logic [NUM_TAG-1:0] slot_ldmem_ready;
   logic [NUM_TAG-1:0] slot_compute_ready;
   logic [NUM_TAG-1:0] slot_stmem_ready;
   logic [NUM_TAG-1:0] slot_next_compute;
   logic [TAG_W-1:0]   ldmem_tag;
   logic [TAG_W-1:0]   compute_tag;
   logic [TAG_W-1:0]   stmem_tag;
   logic               ldmem_tag_ready;
   logic               compute_tag_ready;
   logic               stmem_tag_ready;
   logic               ldmem_tag_done;
   logic               compute_tag_done;
   logic               stmem_tag_done;
   logic [NUM_TAG-1:0] slot_ldmem_done;
   logic [NUM_TAG-1:0] slot_compute_done;
   logic [NUM_TAG-1:0] slot_stmem_done;

   modport slave (
      input  tag_req, tag_reuse, tag_flush,
      input  slot_free, slot_ldmem_ready, slot_compute_ready, slot_stmem_ready, slot_next_compute,
      input  ldmem_tag_done, compute_tag_done, stmem_tag_done,
      output tag_ready, tag_done, alloc_tag,
      output slot_tag_req, slot_tag_reuse, slot_tag_flush,
      output ldmem_tag, compute_tag, stmem_tag,
      output ldmem_tag_ready, compute_tag_ready, stmem_tag_ready,
      output slot_ldmem_done, slot_compute_done, slot_stmem_done
   );

   modport master (
      output tag_req, tag_reuse, tag_flush,
      output slot_free, slot_ldmem_ready, slot_compute_ready, slot_stmem_ready, slot_next_compute,
      output ldmem_tag_done, compute_tag_done, stmem_tag_done,
      input  tag_ready, tag_done, alloc_tag,
      input  slot_tag_req, slot_tag_reuse, slot_tag_flush,
      input  ldmem_tag, compute_tag, stmem_tag,
      input  ldmem_tag_ready, compute_tag_ready, stmem_tag_ready,
      input  slot_ldmem_done, slot_compute_done, slot_stmem_done
   );
endinterface

`default_nettype wire

// File: rtl/tag_sync.sv
// tag_sync : round-robin tag slot allocator with ldmem/compute/stmem pointers and done decode
// rev 1.0
`default_nettype none

module tag_sync #(
   parameter int NUM_TAG = 2,
   parameter int TAG_W   = $clog2(NUM_TAG)
) (
   input  logic        clk,
   input  logic        reset,
   tag_sync_if.slave   bus
);
   localparam logic [NUM_TAG-1:0] C_ONE_HOT_0 = NUM_TAG'(1);
   localparam logic [TAG_W-1:0]   C_LAST_IDX  = TAG_W'(NUM_TAG - 1);

   function automatic logic [TAG_W-1:0] wrap_inc(input logic [TAG_W-1:0] ptr);
      return (ptr == C_LAST_IDX) ? '0 : ptr + 1'b1;
   endfunction

   logic [TAG_W-1:0] r_alloc_tag;
   logic [TAG_W-1:0] r_last_tag;
   logic             r_last_valid;
   logic [TAG_W-1:0] r_ldmem_tag;
   logic [TAG_W-1:0] r_compute_tag;
   logic [TAG_W-1:0] r_stmem_tag;

   logic w_accept;
   logic w_ld_fire;
   logic w_cp_fire;
   logic w_st_fire;
   logic w_cp_advance;

   assign bus.tag_ready = bus.slot_free[r_alloc_tag];
   assign w_accept      = bus.tag_req && bus.tag_ready;
   assign bus.tag_done  = (&bus.slot_free) && !w_accept;
   assign bus.alloc_tag = r_alloc_tag;

   // A reuse colliding with an accepted request is dropped; flush always targets the previous slot.
   assign bus.slot_tag_req   = w_accept ? (C_ONE_HOT_0 << r_alloc_tag) : '0;
   assign bus.slot_tag_reuse = (bus.tag_reuse && r_last_valid && !w_accept) ? (C_ONE_HOT_0 << r_last_tag) : '0;
   assign bus.slot_tag_flush = (bus.tag_flush && r_last_valid) ? (C_ONE_HOT_0 << r_last_tag) : '0;

   assign bus.ldmem_tag         = r_ldmem_tag;
   assign bus.compute_tag       = r_compute_tag;
   assign bus.stmem_tag         = r_stmem_tag;
   assign bus.ldmem_tag_ready   = bus.slot_ldmem_ready[r_ldmem_tag];
   assign bus.compute_tag_ready = bus.slot_compute_ready[r_compute_tag];
   assign bus.stmem_tag_ready   = bus.slot_stmem_ready[r_stmem_tag];

   assign w_ld_fire    = bus.ldmem_tag_done && bus.ldmem_tag_ready;
   assign w_cp_fire    = bus.compute_tag_done && bus.compute_tag_ready;
   assign w_st_fire    = bus.stmem_tag_done && bus.stmem_tag_ready;
   // Reused slots pass through compute repeatedly; only the slot's own flushed-finish moves on.
   assign w_cp_advance = bus.slot_next_compute[r_compute_tag];

   assign bus.slot_ldmem_done   = w_ld_fire ? (C_ONE_HOT_0 << r_ldmem_tag)   : '0;
   assign bus.slot_compute_done = w_cp_fire ? (C_ONE_HOT_0 << r_compute_tag) : '0;
   assign bus.slot_stmem_done   = w_st_fire ? (C_ONE_HOT_0 << r_stmem_tag)   : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_alloc_tag   <= '0;
         r_last_tag    <= '0;
         r_last_valid  <= 1'b0;
         r_ldmem_tag   <= '0;
         r_compute_tag <= '0;
         r_stmem_tag   <= '0;
      end else begin
         if (w_accept) begin
            r_last_tag   <= r_alloc_tag;
            r_last_valid <= 1'b1;
            r_alloc_tag  <= wrap_inc(r_alloc_tag);
         end
         if (w_ld_fire) begin
            r_ldmem_tag <= wrap_inc(r_ldmem_tag);
         end
         if (w_cp_advance) begin
            r_compute_tag <= wrap_inc(r_compute_tag);
         end
         if (w_st_fire) begin
            r_stmem_tag <= wrap_inc(r_stmem_tag);
         end
      end
   end
endmodule

`default_nettype wire
